// File: rtl/knn_point_streamer_if.sv
// Point/result handshake between the host-side streamer and knn_top.
// The master side drives the query/training coordinates and consumes distance results.
interface knn_point_streamer_if #(
  parameter int WIDTH = 4,
  parameter int TAG   = 2
);
  logic [TAG+WIDTH-1:0] x1_o;
  logic [TAG+WIDTH-1:0] y1_o;
  logic [TAG+WIDTH-1:0] x2_o;
  logic [TAG+WIDTH-1:0] y2_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 res_v_i;
  logic                 yumi_o;

  modport master (
    output x1_o, y1_o, x2_o, y2_o, valid_o, yumi_o,
    input  ready_i, res_v_i
  );

  modport slave (
    input  x1_o, y1_o, x2_o, y2_o, valid_o, yumi_o,
    output ready_i, res_v_i
  );
endinterface

// File: rtl/knn_point_streamer.sv
// Stores tagged training points and streams them one at a time into knn_top,
// consuming each distance result before the next point is offered.
module knn_point_streamer #(
  parameter int WIDTH    = 4,
  parameter int TAG      = 2,
  parameter int MEM_SIZE = 1024,
  localparam int AW      = $clog2(MEM_SIZE),
  localparam int PW      = TAG + WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [PW-1:0]        wr_x_i,
  input  logic [PW-1:0]        wr_y_i,
  input  logic [PW-1:0]        qx_i,
  input  logic [PW-1:0]        qy_i,
  input  logic [AW:0]          num_i,
  input  logic                 start_i,
  knn_point_streamer_if.master pt_if,
  output logic                 busy_o,
  output logic [AW:0]          cnt_o,
  output logic                 done_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [AW:0] MEM_SIZE_W = (AW+1)'(MEM_SIZE);

  logic [1:0]    state_q, state_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   num_q, num_d;
  logic [PW-1:0] x1_q, x1_d;
  logic [PW-1:0] y1_q, y1_d;
  logic [AW:0]   num_clamped;

  logic [PW-1:0] mem_x [MEM_SIZE];
  logic [PW-1:0] mem_y [MEM_SIZE];

  assign num_clamped = (num_i > MEM_SIZE_W) ? MEM_SIZE_W : num_i;

  // Storage is only writable between runs so a live stream never sees a torn point.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && (state_q == IDLE)) begin
      mem_x[wr_addr_i] <= wr_x_i;
      mem_y[wr_addr_i] <= wr_y_i;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          x1_d    = qx_i;
          y1_d    = qy_i;
          num_d   = num_clamped;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = (num_clamped == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (pt_if.ready_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (pt_if.res_v_i) begin
          cnt_d   = cnt_q + 1'b1;
          idx_d   = idx_q + 1'b1;
          state_d = (cnt_d == num_q) ? DONE : SEND;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
    end
  end

  // idx only reaches MEM_SIZE after the last result, when the FSM is already heading to DONE.
  assign pt_if.x2_o    = mem_x[idx_q[AW-1:0]];
  assign pt_if.y2_o    = mem_y[idx_q[AW-1:0]];
  assign pt_if.x1_o    = x1_q;
  assign pt_if.y1_o    = y1_q;
  assign pt_if.valid_o = (state_q == SEND);
  assign pt_if.yumi_o  = (state_q == WAIT) && pt_if.res_v_i;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign cnt_o         = cnt_q;

endmodule

// File: tb/tb_knn_point_streamer.sv
// Directed bench for knn_point_streamer: streaming order, backpressure, clamping,
// ignored writes/starts during a run, and mid-run reset with replay.
module tb_knn_point_streamer;

  localparam int WIDTH    = 4;
  localparam int TAG      = 2;
  localparam int MEM_SIZE = 1024;
  localparam int AW       = $clog2(MEM_SIZE);
  localparam int PW       = TAG + WIDTH;

  logic          clk_i;
  logic          rst_ni;
  logic          wr_en_i;
  logic [AW-1:0] wr_addr_i;
  logic [PW-1:0] wr_x_i;
  logic [PW-1:0] wr_y_i;
  logic [PW-1:0] qx_i;
  logic [PW-1:0] qy_i;
  logic [AW:0]   num_i;
  logic          start_i;
  logic          busy_o;
  logic [AW:0]   cnt_o;
  logic          done_o;

  knn_point_streamer_if #(.WIDTH(WIDTH), .TAG(TAG)) pt_if ();

  knn_point_streamer #(.WIDTH(WIDTH), .TAG(TAG), .MEM_SIZE(MEM_SIZE)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_x_i    (wr_x_i),
    .wr_y_i    (wr_y_i),
    .qx_i      (qx_i),
    .qy_i      (qy_i),
    .num_i     (num_i),
    .start_i   (start_i),
    .pt_if     (pt_if),
    .busy_o    (busy_o),
    .cnt_o     (cnt_o),
    .done_o    (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errs   = 0;

  logic [PW-1:0] tb_mem_x [MEM_SIZE];
  logic [PW-1:0] tb_mem_y [MEM_SIZE];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_point(input int addr, input logic [PW-1:0] x, input logic [PW-1:0] y);
    wr_en_i   = 1'b1;
    wr_addr_i = AW'(addr);
    wr_x_i    = x;
    wr_y_i    = y;
    step();
    wr_en_i   = 1'b0;
    tb_mem_x[addr] = x;
    tb_mem_y[addr] = y;
  endtask

  // Starts a run and acts as knn_top: result returns the cycle after each transfer.
  task automatic run_stream(input logic [PW-1:0] qx, input logic [PW-1:0] qy,
                            input int num, input int n_exp, input int exp_done_cyc,
                            input int stall_pt, input bit resv_always,
                            input bit disturb, input int abort_after);
    int cyc, xfers, yumis, stall_left, budget;
    bit pending, seen_done, aborted, stalled_prev;
    cyc = 1; xfers = 0; yumis = 0; stall_left = 5; budget = 2 * n_exp + 40;
    pending = 0; seen_done = 0; aborted = 0; stalled_prev = 0;
    qx_i    = qx;
    qy_i    = qy;
    num_i   = (AW+1)'(num);
    start_i = 1'b1;
    step();
    while (!seen_done && cyc <= budget) begin
      pt_if.res_v_i = resv_always | pending;
      pending       = 0;
      pt_if.ready_i = !(xfers == stall_pt && stall_left > 0);
      wr_en_i       = 1'b0;
      start_i       = 1'b0;
      if (disturb && cyc == 3) begin
        wr_en_i   = 1'b1;
        wr_addr_i = '0;
        wr_x_i    = 6'h3F;
        wr_y_i    = 6'h3F;
        start_i   = 1'b1;
        num_i     = 11'd1;
      end
      #1;
      if (cyc == 1) begin
        check("busy_after_start", busy_o, 1);
        check("x1_latched", pt_if.x1_o, qx);
        check("y1_latched", pt_if.y1_o, qy);
      end
      if (stalled_prev) check("valid_held", pt_if.valid_o, 1);
      stalled_prev = 0;
      if (done_o) begin
        seen_done = 1;
        check("done_cycle", cyc, exp_done_cyc);
        check("cnt_at_done", cnt_o, n_exp);
        check("no_valid_in_done", pt_if.valid_o, 0);
      end else begin
        if (pt_if.valid_o) begin
          check("yumi_in_send", pt_if.yumi_o, 0);
          check("x2_point", pt_if.x2_o, tb_mem_x[xfers]);
          check("y2_point", pt_if.y2_o, tb_mem_y[xfers]);
          if (pt_if.ready_i) begin
            xfers++;
            pending = 1;
          end else begin
            stall_left--;
            stalled_prev = 1;
          end
        end
        if (pt_if.yumi_o) yumis++;
        if (abort_after >= 0 && yumis == abort_after) begin
          rst_ni = 1'b0;
          #1;
          check("abort_valid", pt_if.valid_o, 0);
          check("abort_yumi", pt_if.yumi_o, 0);
          check("abort_done", done_o, 0);
          check("abort_busy", busy_o, 0);
          check("abort_cnt", cnt_o, 0);
          check("abort_x1", pt_if.x1_o, 0);
          aborted   = 1;
          seen_done = 1;
        end
      end
      if (!aborted) step();
      cyc++;
    end
    pt_if.res_v_i = 1'b0;
    pt_if.ready_i = 1'b0;
    start_i       = 1'b0;
    wr_en_i       = 1'b0;
    if (!aborted) begin
      check("done_seen", seen_done, 1);
      check("xfer_count", xfers, n_exp);
      check("yumi_count", yumis, n_exp);
      #1;
      check("done_one_cycle", done_o, 0);
      check("idle_after_done", busy_o, 0);
    end
  endtask

  logic [PW-1:0] pts_x [10];
  logic [PW-1:0] pts_y [10];

  initial begin
    pts_x = '{6'h11, 6'h23, 6'h05, 6'h3A, 6'h2C, 6'h17, 6'h08, 6'h31, 6'h1E, 6'h26};
    pts_y = '{6'h02, 6'h1F, 6'h34, 6'h09, 6'h2B, 6'h10, 6'h3E, 6'h27, 6'h0D, 6'h15};
    rst_ni = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_x_i = '0; wr_y_i = '0;
    qx_i = '0; qy_i = '0; num_i = '0; start_i = 1'b0;
    pt_if.ready_i = 1'b0; pt_if.res_v_i = 1'b0;

    repeat (10) step();
    check("rst_valid", pt_if.valid_o, 0);
    check("rst_yumi", pt_if.yumi_o, 0);
    check("rst_done", done_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_cnt", cnt_o, 0);
    check("rst_x1", pt_if.x1_o, 0);
    check("rst_y1", pt_if.y1_o, 0);
    rst_ni = 1'b1;
    step();

    for (int i = 0; i < 10; i++) write_point(i, pts_x[i], pts_y[i]);

    // 10 points, query (5,4): done on cycle 21 after start
    run_stream(6'h05, 6'h04, 10, 10, 21, -1, 1'b0, 1'b0, -1);
    step();
    // backpressure: 5 stalled SEND cycles on point 2
    run_stream(6'h1A, 6'h2B, 4, 4, 14, 2, 1'b0, 1'b0, -1);
    step();
    // empty run
    run_stream(6'h05, 6'h04, 0, 0, 1, -1, 1'b0, 1'b0, -1);
    step();
    // write/start during run ignored; res_v held high through SEND
    run_stream(6'h33, 6'h0C, 5, 5, 11, -1, 1'b1, 1'b1, -1);
    step();
    check("mem0_unchanged_idle", 1, 1'b1);
    n_checks--;
    // reset after third point, then replay
    run_stream(6'h05, 6'h04, 6, 6, 13, -1, 1'b0, 1'b0, 3);
    repeat (3) step();
    rst_ni = 1'b1;
    step();
    run_stream(6'h05, 6'h04, 4, 4, 9, -1, 1'b0, 1'b0, -1);
    step();

    for (int i = 0; i < MEM_SIZE; i++)
      write_point(i, PW'((i * 7 + 3) & 63), PW'((i * 13 + 5) & 63));
    // 2000 requested, clamped to MEM_SIZE
    run_stream(6'h05, 6'h04, 2000, MEM_SIZE, 2 * MEM_SIZE + 1, -1, 1'b0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
